// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg : request kinds, opcodes, formats and FSM states for the encoder
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_pkg;

  typedef enum logic [4:0] {
    K_RTYPE = 5'd0,  K_ITYPE = 5'd1,  K_LOAD  = 5'd2,  K_STORE = 5'd3,
    K_BRANCH = 5'd4, K_JAL   = 5'd5,  K_JALR  = 5'd6,  K_LUI   = 5'd7,
    K_AUIPC = 5'd8,  K_LI    = 5'd9,
    K_RTI   = 5'd16, K_RSI   = 5'd17, K_RDI   = 5'd18, K_SND   = 5'd19,
    K_PPU   = 5'd20, K_SAC   = 5'd21, K_RND   = 5'd22, K_UAD   = 5'd23
  } req_kind_e;

  // Opcodes shared with the instruction decoder
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_rti    = 7'b0001000;
  localparam logic [6:0] c_op_rsi    = 7'b0001001;
  localparam logic [6:0] c_op_rdi    = 7'b0001010;
  localparam logic [6:0] c_op_snd    = 7'b0001011;
  localparam logic [6:0] c_op_ppu    = 7'b0101000;
  localparam logic [6:0] c_op_sac    = 7'b0101001;
  localparam logic [6:0] c_op_rnd    = 7'b0101010;
  localparam logic [6:0] c_op_uad    = 7'b0101011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LI_LO = 1'b1} enc_state_e;

  // True when v is representable as a two's-complement value of 'bits' bits
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] s;
    s = 32'($signed(v) >>> (bits - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_field_packer.sv
// ---------------------------------------------------------------------------
// instr_field_packer : combinational field-to-word packer with legality check
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_field_packer
  import instr_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  fmt_e       fmt;
  logic [6:0] opcode;
  logic       w_shift_imm;

  assign w_shift_imm = (kind == K_ITYPE) && (funct3[1:0] == 2'b01);

  always_comb begin
    fmt     = FMT_I;
    opcode  = c_op_itype;
    illegal = 1'b0;
    case (kind)
      K_RTYPE:  begin fmt = FMT_R; opcode = c_op_rtype; end
      K_ITYPE:  opcode = c_op_itype;
      K_LOAD:   opcode = c_op_load;
      K_STORE:  begin fmt = FMT_S; opcode = c_op_store; end
      K_BRANCH: begin
        fmt     = FMT_B;
        opcode  = c_op_branch;
        illegal = imm[0] || !fits_signed(imm, 13);
      end
      K_JAL: begin
        fmt     = FMT_J;
        opcode  = c_op_jal;
        illegal = imm[0] || !fits_signed(imm, 21);
      end
      K_JALR:   opcode = c_op_jalr;
      K_LUI:    begin fmt = FMT_U; opcode = c_op_lui; end
      K_AUIPC:  begin fmt = FMT_U; opcode = c_op_auipc; end
      K_RTI:    opcode = c_op_rti;
      K_RSI:    opcode = c_op_rsi;
      K_RDI:    opcode = c_op_rdi;
      K_SND:    opcode = c_op_snd;
      K_PPU:    opcode = c_op_ppu;
      K_SAC:    opcode = c_op_sac;
      K_RND:    opcode = c_op_rnd;
      K_UAD:    opcode = c_op_uad;
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R: word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (w_shift_imm) word = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
        else             word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_stream_encoder.sv
// ---------------------------------------------------------------------------
// instr_stream_encoder : assembles symbolic requests into sequential imem words
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_stream_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_kind,
  input  logic [2:0]        req_funct3,
  input  logic              req_alt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] wptr,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              full_q, full_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [11:0]       pend_lo_q, pend_lo_d;

  logic [4:0]        pk_kind, pk_rd, pk_rs1, pk_rs2;
  logic [2:0]        pk_funct3;
  logic              pk_alt;
  logic [31:0]       pk_imm, pk_word;
  logic              pk_illegal;

  logic              w_accept, w_is_li, w_li_short, w_li_two, w_write;
  logic [ADDR_W-1:0] w_waddr;

  assign req_ready  = (state_q == S_IDLE) && !full_q;
  assign w_accept   = req_valid && req_ready;
  assign w_is_li    = (req_kind == K_LI);
  assign w_li_short = fits_signed(req_imm, 12);
  assign w_li_two   = !w_li_short && (req_imm[11:0] != 12'd0);

  // LI is lowered to ADDI/LUI here; the held ADDI is re-packed in LI_LO
  always_comb begin
    pk_kind   = req_kind;
    pk_funct3 = req_funct3;
    pk_alt    = req_alt;
    pk_rd     = req_rd;
    pk_rs1    = req_rs1;
    pk_rs2    = req_rs2;
    pk_imm    = req_imm;
    if (state_q == S_LI_LO) begin
      pk_kind   = K_ITYPE;
      pk_funct3 = 3'b000;
      pk_alt    = 1'b0;
      pk_rd     = pend_rd_q;
      pk_rs1    = pend_rd_q;
      pk_rs2    = 5'd0;
      pk_imm    = {{20{pend_lo_q[11]}}, pend_lo_q};
    end else if (w_is_li) begin
      pk_funct3 = 3'b000;
      pk_alt    = 1'b0;
      pk_rs2    = 5'd0;
      if (w_li_short) begin
        pk_kind = K_ITYPE;
        pk_rs1  = 5'd0;
      end else begin
        // Rounding the upper part compensates for the sign-extended low ADDI
        pk_kind = K_LUI;
        pk_imm  = req_imm + 32'h0000_0800;
      end
    end
  end

  instr_field_packer u_packer (
    .kind    (pk_kind),
    .funct3  (pk_funct3),
    .alt     (pk_alt),
    .rd      (pk_rd),
    .rs1     (pk_rs1),
    .rs2     (pk_rs2),
    .imm     (pk_imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    full_d      = full_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    pend_rd_d   = pend_rd_q;
    pend_lo_d   = pend_lo_q;
    w_write     = 1'b0;
    w_waddr     = wptr_q;
    case (state_q)
      S_IDLE: begin
        if (base_load) begin
          wptr_d  = base_addr;
          full_d  = 1'b0;
          w_waddr = base_addr;
        end
        if (w_accept) begin
          if (pk_illegal) begin
            err_d = 1'b1;
          end else begin
            w_write = 1'b1;
            if (w_is_li && w_li_two) begin
              state_d   = S_LI_LO;
              pend_rd_d = req_rd;
              pend_lo_d = req_imm[11:0];
            end
          end
        end
      end
      S_LI_LO: begin
        w_write = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (w_write) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = w_waddr;
      mem_wdata_d = pk_word;
      if (w_waddr == c_last_addr) begin
        wptr_d = '0;
        full_d = 1'b1;
      end else begin
        wptr_d = w_waddr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      full_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      pend_rd_q   <= '0;
      pend_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      full_q      <= full_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      pend_rd_q   <= pend_rd_d;
      pend_lo_q   <= pend_lo_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wptr      = wptr_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_stream_encoder : directed + random bench against a word-queue model
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_stream_encoder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_kind;
  logic [2:0]        req_funct3;
  logic              req_alt;
  logic [4:0]        req_rd, req_rs1, req_rs2;
  logic [31:0]       req_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] wptr;
  logic              full;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Model state: pending words of an unfinished LI live in a queue
  int          m_wptr;
  bit          m_full;
  logic [31:0] m_pending[$];
  bit          m_we, m_err;
  int          m_addr;
  logic [31:0] m_data;

  int legal_k[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23};

  instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_funct3 (req_funct3),
    .req_alt    (req_alt),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .wptr       (wptr),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_word(input logic [31:0] op, input logic [31:0] f3,
                                         input logic [31:0] rd, input logic [31:0] rs1,
                                         input logic [31:0] imm);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  // Returns number of words (0 = rejected)
  function automatic int encode(input logic [31:0] kind, input logic [31:0] f3,
                                input logic [31:0] alt, input logic [31:0] rd,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm,
                                output logic [31:0] w0, output logic [31:0] w1);
    int si;
    logic [31:0] hi;
    si = $signed(imm);
    w0 = 32'd0;
    w1 = 32'd0;
    case (kind)
      0: w0 = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: if (f3 == 1 || f3 == 5)
           w0 = (alt << 30) | ((imm % 32) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         else
           w0 = i_word(32'h13, f3, rd, rs1, imm);
      2: w0 = i_word(32'h03, f3, rd, rs1, imm);
      3: w0 = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | ((imm & 31) << 7) | 32'h23;
      4: begin
        if (imm % 2 == 1 || si < -4096 || si > 4095) return 0;
        w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
             | (((imm >> 11) & 1) << 7) | 32'h63;
      end
      5: begin
        if (imm % 2 == 1 || si < -1048576 || si > 1048575) return 0;
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
      end
      6: w0 = i_word(32'h67, f3, rd, rs1, imm);
      7: w0 = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      8: w0 = (imm & 32'hFFFFF000) | (rd << 7) | 32'h17;
      9: begin
        if (si >= -2048 && si <= 2047) begin
          w0 = i_word(32'h13, 0, rd, 0, imm);
        end else begin
          hi = (imm + 32'h800) >> 12;
          w0 = (hi << 12) | (rd << 7) | 32'h37;
          if ((imm & 32'hFFF) != 0) begin
            w1 = i_word(32'h13, 0, rd, rd, imm);
            return 2;
          end
        end
      end
      16: w0 = i_word(32'h08, f3, rd, rs1, imm);
      17: w0 = i_word(32'h09, f3, rd, rs1, imm);
      18: w0 = i_word(32'h0A, f3, rd, rs1, imm);
      19: w0 = i_word(32'h0B, f3, rd, rs1, imm);
      20: w0 = i_word(32'h28, f3, rd, rs1, imm);
      21: w0 = i_word(32'h29, f3, rd, rs1, imm);
      22: w0 = i_word(32'h2A, f3, rd, rs1, imm);
      23: w0 = i_word(32'h2B, f3, rd, rs1, imm);
      default: return 0;
    endcase
    return 1;
  endfunction

  task automatic model_reset();
    m_wptr = 0; m_full = 0; m_pending.delete();
    m_we = 0; m_err = 0; m_addr = 0; m_data = 32'd0;
  endtask

  task automatic model_write(input logic [31:0] w);
    m_we = 1; m_addr = m_wptr; m_data = w;
    if (m_wptr == DEPTH - 1) begin m_full = 1; m_wptr = 0; end
    else m_wptr++;
  endtask

  task automatic model_step();
    bit ready;
    int n;
    logic [31:0] w0, w1;
    m_we = 0; m_err = 0;
    ready = (m_pending.size() == 0) && !m_full;
    if (m_pending.size() > 0) begin
      model_write(m_pending.pop_front());
    end else begin
      if (base_load) begin m_wptr = base_addr; m_full = 0; end
      if (req_valid && ready) begin
        n = encode(req_kind, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm, w0, w1);
        if (n == 0) m_err = 1;
        else begin
          model_write(w0);
          if (n == 2) m_pending.push_back(w1);
        end
      end
    end
  endtask

  // Inputs are set just before calling; one clock with checks either side
  task automatic cycle();
    #1;
    chk("req_ready", req_ready, (m_pending.size() == 0) && !m_full);
    @(posedge clk);
    model_step();
    #1;
    chk("mem_we", mem_we, m_we);
    if (m_we) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
    end
    chk("wptr", wptr, m_wptr);
    chk("full", full, m_full);
    chk("err", err, m_err);
    @(negedge clk);
  endtask

  task automatic setreq(input logic v, input logic [4:0] k, input logic [2:0] f3,
                        input logic a, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
    req_valid = v; req_kind = k; req_funct3 = f3; req_alt = a;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic idle();
    setreq(1'b0, 5'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    base_load = 1'b0;
  endtask

  task automatic load_ptr(input int a);
    base_load = 1'b1; base_addr = ADDR_W'(a);
  endtask

  initial begin
    logic [31:0] imm;
    int kind;
    rst = 1'b1; base_addr = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1); chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);   chk("rst_wdata", mem_wdata, 0);
    chk("rst_wptr", wptr, 0);       chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    setreq(1, 5'd0, 3'd0, 0, 5'd1, 5'd2, 5'd3, 32'd0); cycle();
    chk("t1_word", mem_wdata, 32'h003100B3); chk("t1_addr", mem_addr, 0); chk("t1_wptr", wptr, 1);

    setreq(1, 5'd9, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345FFF); cycle();
    chk("t2_lui", mem_wdata, 32'h123462B7);
    idle(); cycle();
    chk("t2_addi", mem_wdata, 32'hFFF28293); chk("t2_addr", mem_addr, 2);

    setreq(1, 5'd9, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFB); cycle();
    chk("t3_li_small", mem_wdata, 32'hFFB00093);
    setreq(1, 5'd9, 3'd0, 0, 5'd2, 5'd0, 5'd0, 32'h00040000); cycle();
    chk("t3_li_lui", mem_wdata, 32'h00040137);
    idle(); cycle();

    setreq(1, 5'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8); cycle();
    chk("t4_branch", mem_wdata, 32'h00208463);
    setreq(1, 5'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd9); cycle();
    chk("t4_err", err, 1);
    setreq(1, 5'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd4096); cycle();
    setreq(1, 5'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00100000); cycle();
    setreq(1, 5'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'hFFF00000); cycle();
    setreq(1, 5'd12, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd0); cycle();

    setreq(1, 5'd19, 3'd0, 0, 5'd0, 5'd4, 5'd0, 32'd0); cycle();
    chk("t6_snd", mem_wdata, 32'h0002000B);

    // Fill the last four words, then try to write while full
    idle(); load_ptr(DEPTH - 4); cycle(); base_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setreq(1, 5'd1, 3'd5, 1, 5'(i), 5'd7, 5'd0, 32'(i + 3)); cycle();
    end
    chk("t5_full", full, 1); chk("t5_wptr", wptr, 0); chk("t5_ready", req_ready, 0);
    cycle();
    load_ptr(2); cycle(); base_load = 1'b0;
    chk("t5_cleared", full, 0);
    setreq(1, 5'd3, 3'd2, 0, 5'd0, 5'd3, 5'd4, 32'hFFFFFFF0); cycle();
    chk("t5_addr2", mem_addr, 2);
    load_ptr(5); cycle(); base_load = 1'b0;
    chk("t5_coincide", mem_addr, 5);

    // Two-word LI straddling the end of memory
    idle(); load_ptr(DEPTH - 1); setreq(1, 5'd9, 3'd0, 0, 5'd7, 5'd0, 5'd0, 32'h80000123); cycle();
    idle(); cycle();
    chk("li_wrap_addr", mem_addr, 0); chk("li_wrap_full", full, 1);
    load_ptr(0); cycle(); base_load = 1'b0;

    // Reset during the second word of LI
    setreq(1, 5'd9, 3'd0, 0, 5'd3, 5'd0, 5'd0, 32'h7654ABCD); cycle();
    idle(); rst = 1'b1; #1;
    model_reset();
    chk("mid_rst_we", mem_we, 0); chk("mid_rst_wptr", wptr, 0);
    chk("mid_rst_ready", req_ready, 1); chk("mid_rst_wdata", mem_wdata, 0);
    @(negedge clk); rst = 1'b0;
    cycle();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) kind = $urandom_range(0, 1) ? $urandom_range(10, 15)
                                                                 : $urandom_range(24, 31);
      else kind = legal_k[$urandom_range(0, 17)];
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = $urandom;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      setreq(($urandom_range(0, 4) != 0), 5'(kind), 3'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom), imm);
      base_load = ($urandom_range(0, 9) == 0);
      base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    idle(); cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
